fwd_hazard_unit: RTL and testbench

- Parametrised forwarding and hazard controller for the 5-stage MIPS pipeline (IF/ID/EXE/MEM/WB).
- Decides operand forwarding during ID, registers the decision with the ID→EXE advance, and drives EXE operands from registered select codes. It also raises load-use stalls, branch flushes and global memory-wait holds.
- Sits between the ID control decode and the EXE ALU inputs; owns the ID→EXE operand registers.
- Keeps its own 3-entry in-flight destination tracker for EXE, MEM and WB, plus a last-write-back buffer, so it does not depend on the register file being write-through.

---
 rtl/fwd_pkg.sv | 29 ++
 rtl/fwd_match.sv | 34 +++
 rtl/fwd_hazard_unit.sv | 168 ++++++++++++++++
 tb/tb_fwd_hazard_unit.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fwd_pkg.sv
// Shared types for the forwarding/hazard controller: forward select codes
// and the in-flight destination tracker entry.
package fwd_pkg;

    // Tracker address width; wide enough for any ADDR_W up to this value.
    localparam int FWD_TRK_AW = 8;

    typedef logic [FWD_TRK_AW-1:0] trk_addr_t;

    // Where an EXE operand comes from.
    typedef enum logic [1:0] {
        FWD_RF   = 2'd0,   // registered register-file value
        FWD_MEM  = 2'd1,   // ALU result now held in MEM
        FWD_WB   = 2'd2,   // value being written back this cycle
        FWD_PREV = 2'd3    // last write-back buffer
    } fwd_sel_e;

    // One in-flight instruction as seen by the forwarding logic.
    typedef struct packed {
        logic      v;
        logic      wen;
        logic      ld;
        trk_addr_t addr;
    } trk_entry_t;

    localparam trk_entry_t TRK_BUBBLE = '{v: 1'b0, wen: 1'b0, ld: 1'b0,
                                          addr: {FWD_TRK_AW{1'b0}}};

endpackage

// File: rtl/fwd_match.sv
// Match and priority for one source register against the E/M/W tracker.
// Entry 0 is E (youngest), 1 is M, 2 is W. Returns the forward code and a
// load-use flag (E holds a load producing this source; no code possible).
module fwd_match
    import fwd_pkg::*;
(
    input  trk_addr_t        i_src,
    input  logic             i_used,
    input  trk_entry_t [2:0] i_ent,
    output fwd_sel_e         o_sel,
    output logic             o_load_use
);

    logic w_src_nz;
    logic w_match;

    assign w_src_nz = (i_src != {FWD_TRK_AW{1'b0}});

    // Scan oldest to youngest so the youngest matching producer is written last and wins.
    always_comb begin
        o_sel      = FWD_RF;
        o_load_use = 1'b0;
        w_match    = 1'b0;
        for (int k = 2; k >= 0; k--) begin
            w_match    = i_used & w_src_nz & i_ent[k].v & i_ent[k].wen &
                         (i_ent[k].addr == i_src);
            o_load_use = w_match ? (i_ent[k].ld && (k == 0)) : o_load_use;
            o_sel      = w_match ? ((k == 0) ? (i_ent[k].ld ? FWD_RF : FWD_MEM)
                                             : ((k == 1) ? FWD_WB : FWD_PREV))
                                 : o_sel;
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding and hazard controller for the 5-stage pipeline. Decides operand
// forwarding in ID, registers it with the ID->EXE advance and muxes the EXE
// operands. Raises load-use stalls, branch flushes and memory-wait holds.
// Optional feature macro: FWD_STORE_EN (store data forwarded from a load
// in MEM instead of stalling).
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [ADDR_W-1:0] id_rs_addr,
    input  logic [ADDR_W-1:0] id_rt_addr,
    input  logic              id_rs_used,
    input  logic              id_rt_used,
    input  logic              id_wen,
    input  logic [ADDR_W-1:0] id_waddr,
    input  logic              id_is_load,
    input  logic              id_is_store,
    input  logic              id_b_imm,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [DATA_W-1:0] rf_data_a,
    input  logic [DATA_W-1:0] rf_data_b,
    input  logic [DATA_W-1:0] mem_alu_result,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [DATA_W-1:0] mem_store_raw,
    input  logic              branch_taken,
    input  logic              mem_busy,
    output logic              stall_id,
    output logic              flush_id,
    output logic              hold_all,
    output logic [DATA_W-1:0] exe_opa,
    output logic [DATA_W-1:0] exe_opb,
    output logic [DATA_W-1:0] exe_rt_data,
    output logic [DATA_W-1:0] mem_store_data
);

`ifdef FWD_STORE_EN
    localparam bit STORE_FWD = 1'b1;
`else
    localparam bit STORE_FWD = 1'b0;
`endif

    // Tracker and registered decisions
    trk_entry_t        r_trk_e, r_trk_m, r_trk_w;
    fwd_sel_e          r_sel_a, r_sel_b, r_sel_t;
    logic              r_sel_m, r_sel_m_mem;
    logic [DATA_W-1:0] r_opa, r_opb, r_rt_base;
    trk_addr_t         r_pw_addr;
    logic [DATA_W-1:0] r_pw_data;

    // ID-side decode
    trk_entry_t [2:0]  w_ent;
    fwd_sel_e          w_sel_rs, w_sel_rt;
    logic              w_lu_rs, w_lu_rt;
    logic              w_hold, w_flush, w_stall, w_issue;
    logic              w_rt_store_only, w_lu_rt_stall, w_sel_m;
    logic [DATA_W-1:0] w_pw_value;

    assign w_ent = {r_trk_w, r_trk_m, r_trk_e};

    fwd_match u_match_rs (
        .i_src      (trk_addr_t'(id_rs_addr)),
        .i_used     (id_rs_used),
        .i_ent      (w_ent),
        .o_sel      (w_sel_rs),
        .o_load_use (w_lu_rs)
    );

    fwd_match u_match_rt (
        .i_src      (trk_addr_t'(id_rt_addr)),
        .i_used     (id_rt_used),
        .i_ent      (w_ent),
        .o_sel      (w_sel_rt),
        .o_load_use (w_lu_rt)
    );

    // A store whose rt is only its store data can take a loaded value late, in MEM.
    assign w_rt_store_only = id_is_store & id_b_imm;
    assign w_lu_rt_stall   = w_lu_rt & ~(STORE_FWD & w_rt_store_only);
    assign w_sel_m         = STORE_FWD & w_rt_store_only & w_lu_rt;

    // Hold gates everything; flush beats stall.
    assign w_hold  = mem_busy;
    assign w_flush = branch_taken & ~w_hold;
    assign w_stall = id_valid & ~w_hold & ~w_flush & (w_lu_rs | w_lu_rt_stall);
    assign w_issue = id_valid & ~w_stall & ~w_flush;

    assign hold_all = w_hold;
    assign flush_id = w_flush;
    assign stall_id = w_stall;

    // Register zero never supplies a value, even from the write-back buffer.
    assign w_pw_value = (r_pw_addr != {FWD_TRK_AW{1'b0}}) ? r_pw_data : {DATA_W{1'b0}};

    function automatic logic [DATA_W-1:0] fwd_pick(
        input fwd_sel_e          sel,
        input logic [DATA_W-1:0] base,
        input logic [DATA_W-1:0] mem_v,
        input logic [DATA_W-1:0] wb_v,
        input logic [DATA_W-1:0] prev_v
    );
        case (sel)
            FWD_RF:   fwd_pick = base;
            FWD_MEM:  fwd_pick = mem_v;
            FWD_WB:   fwd_pick = wb_v;
            FWD_PREV: fwd_pick = prev_v;
            default:  fwd_pick = base;
        endcase
    endfunction

    assign exe_opa     = fwd_pick(r_sel_a, r_opa,     mem_alu_result, wb_data, w_pw_value);
    assign exe_opb     = fwd_pick(r_sel_b, r_opb,     mem_alu_result, wb_data, w_pw_value);
    assign exe_rt_data = fwd_pick(r_sel_t, r_rt_base, mem_alu_result, wb_data, w_pw_value);

    assign mem_store_data = (STORE_FWD && r_sel_m_mem) ? wb_data : mem_store_raw;

    // Pipeline advance: tracker shift, ID->EXE decision/operand capture, write-back buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_trk_e     <= TRK_BUBBLE;
            r_trk_m     <= TRK_BUBBLE;
            r_trk_w     <= TRK_BUBBLE;
            r_sel_a     <= FWD_RF;
            r_sel_b     <= FWD_RF;
            r_sel_t     <= FWD_RF;
            r_sel_m     <= 1'b0;
            r_sel_m_mem <= 1'b0;
            r_opa       <= {DATA_W{1'b0}};
            r_opb       <= {DATA_W{1'b0}};
            r_rt_base   <= {DATA_W{1'b0}};
            r_pw_addr   <= {FWD_TRK_AW{1'b0}};
            r_pw_data   <= {DATA_W{1'b0}};
        end else if (!w_hold) begin
            r_trk_w     <= r_trk_m;
            r_trk_m     <= r_trk_e;
            r_sel_m_mem <= r_sel_m;
            if (w_issue) begin
                r_trk_e   <= '{v: 1'b1, wen: id_wen, ld: id_is_load,
                               addr: trk_addr_t'(id_waddr)};
                r_sel_a   <= w_sel_rs;
                r_sel_b   <= id_b_imm ? FWD_RF : w_sel_rt;
                r_sel_t   <= w_sel_rt;
                r_sel_m   <= w_sel_m;
                r_opa     <= rf_data_a;
                r_opb     <= id_b_imm ? id_imm : rf_data_b;
                r_rt_base <= rf_data_b;
            end else begin
                r_trk_e   <= TRK_BUBBLE;
                r_sel_a   <= FWD_RF;
                r_sel_b   <= FWD_RF;
                r_sel_t   <= FWD_RF;
                r_sel_m   <= 1'b0;
                r_opa     <= {DATA_W{1'b0}};
                r_opb     <= {DATA_W{1'b0}};
                r_rt_base <= {DATA_W{1'b0}};
            end
            if (r_trk_w.v && r_trk_w.wen && (r_trk_w.addr != {FWD_TRK_AW{1'b0}})) begin
                r_pw_addr <= r_trk_w.addr;
                r_pw_data <= wb_data;
            end
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit. Inputs change 1 ns after the rising
// edge; outputs are sampled 1 ns after inputs change, away from the edge.
module tb_fwd_hazard_unit;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          id_valid, id_rs_used, id_rt_used, id_wen;
    logic          id_is_load, id_is_store, id_b_imm;
    logic [AW-1:0] id_rs_addr, id_rt_addr, id_waddr;
    logic [DW-1:0] id_imm, rf_data_a, rf_data_b;
    logic [DW-1:0] mem_alu_result, wb_data, mem_store_raw;
    logic          branch_taken, mem_busy;
    logic          stall_id, flush_id, hold_all;
    logic [DW-1:0] exe_opa, exe_opb, exe_rt_data, mem_store_data;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fwd_hazard_unit #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk            (clk),
        .rst            (rst),
        .id_valid       (id_valid),
        .id_rs_addr     (id_rs_addr),
        .id_rt_addr     (id_rt_addr),
        .id_rs_used     (id_rs_used),
        .id_rt_used     (id_rt_used),
        .id_wen         (id_wen),
        .id_waddr       (id_waddr),
        .id_is_load     (id_is_load),
        .id_is_store    (id_is_store),
        .id_b_imm       (id_b_imm),
        .id_imm         (id_imm),
        .rf_data_a      (rf_data_a),
        .rf_data_b      (rf_data_b),
        .mem_alu_result (mem_alu_result),
        .wb_data        (wb_data),
        .mem_store_raw  (mem_store_raw),
        .branch_taken   (branch_taken),
        .mem_busy       (mem_busy),
        .stall_id       (stall_id),
        .flush_id       (flush_id),
        .hold_all       (hold_all),
        .exe_opa        (exe_opa),
        .exe_opb        (exe_opb),
        .exe_rt_data    (exe_rt_data),
        .mem_store_data (mem_store_data)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_id(input logic v, input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                          input logic rsu, input logic rtu, input logic wen,
                          input logic [AW-1:0] wa, input logic ld, input logic st,
                          input logic bimm, input logic [DW-1:0] imm);
        id_valid    = v;
        id_rs_addr  = rs;
        id_rt_addr  = rt;
        id_rs_used  = rsu;
        id_rt_used  = rtu;
        id_wen      = wen;
        id_waddr    = wa;
        id_is_load  = ld;
        id_is_store = st;
        id_b_imm    = bimm;
        id_imm      = imm;
    endtask

    task automatic nop();
        set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0);
        rf_data_a = 32'h0;
        rf_data_b = 32'h0;
    endtask

    task automatic drain();
        nop();
        mem_alu_result = 32'h0;
        wb_data        = 32'h0;
        mem_store_raw  = 32'h0;
        branch_taken   = 1'b0;
        mem_busy       = 1'b0;
        repeat (3) step();
    endtask

    initial begin
        rst = 1'b1;
        nop();
        mem_alu_result = 32'h0;
        wb_data        = 32'h0;
        mem_store_raw  = 32'h0;
        branch_taken   = 1'b0;
        mem_busy       = 1'b1;
        step();
        step();

        // Reset state
        check("rst_hold_follows_busy", hold_all, 32'h1);
        mem_busy = 1'b0;
        #1;
        check("rst_hold_low", hold_all, 32'h0);
        check("rst_stall", stall_id, 32'h0);
        check("rst_flush", flush_id, 32'h0);
        check("rst_opa", exe_opa, 32'h0);
        check("rst_opb", exe_opb, 32'h0);
        check("rst_rt_data", exe_rt_data, 32'h0);
        check("rst_store_data", mem_store_data, 32'h0);
        rst = 1'b0;
        step();

        // add $3,$1,$2 ; sub $4,$3,$5 -> EXE->EXE forward from MEM
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 32'h0);
        rf_data_a = 32'h1; rf_data_b = 32'h2; #1;
        check("t1_add_nostall", stall_id, 32'h0);
        step();
        set_id(1'b1, 5'd3, 5'd5, 1'b1, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0, 32'h0);
        rf_data_a = 32'h0; rf_data_b = 32'h5; #1;
        check("t1_add_opa", exe_opa, 32'h1);
        check("t1_add_opb", exe_opb, 32'h2);
        check("t1_sub_nostall", stall_id, 32'h0);
        step();
        nop(); mem_alu_result = 32'h10; #1;
        check("t1_sub_opa_fwd", exe_opa, 32'h10);
        check("t1_sub_opb_rf", exe_opb, 32'h5);
        mem_alu_result = 32'h11; #1;
        check("t1_sub_opa_live", exe_opa, 32'h11);
        drain();

        // lw $3 ; add $4,$3,$3 -> one stall cycle, then WB forward on both
        set_id(1'b1, 5'd0, 5'd3, 1'b1, 1'b0, 1'b1, 5'd3, 1'b1, 1'b0, 1'b1, 32'h0);
        #1; step();
        set_id(1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0, 32'h0);
        #1;
        check("t2_loaduse_stall", stall_id, 32'h1);
        step();
        check("t2_stall_one_cycle", stall_id, 32'h0);
        step();
        nop(); wb_data = 32'h55; #1;
        check("t2_opa_wb", exe_opa, 32'h55);
        check("t2_opb_wb", exe_opb, 32'h55);
        drain();

        // Producer of $7 three ahead; consumer sees stale rf -> last write-back buffer
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 32'h0);
        #1; step();
        nop(); step(); step();
        set_id(1'b1, 5'd7, 5'd0, 1'b1, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 32'h0);
        rf_data_a = 32'h0; wb_data = 32'hAB; #1;
        check("t3_nostall", stall_id, 32'h0);
        step();
        nop(); wb_data = 32'h11; mem_alu_result = 32'h22; #1;
        check("t3_opa_prev", exe_opa, 32'hAB);
        drain();

        // Write to $0 then consumer of $0 -> never forwarded
        set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 32'h99);
        #1; step();
        set_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 32'h0);
        rf_data_a = 32'h0; #1;
        check("t4_nostall", stall_id, 32'h0);
        step();
        nop(); mem_alu_result = 32'h99; wb_data = 32'h99; #1;
        check("t4_opa_zero", exe_opa, 32'h0);
        drain();

        // Taken branch with a load-use in ID -> flush wins, ID instruction becomes a bubble
        set_id(1'b1, 5'd0, 5'd3, 1'b1, 1'b0, 1'b1, 5'd3, 1'b1, 1'b0, 1'b1, 32'h0);
        #1; step();
        set_id(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0, 32'h0);
        rf_data_a = 32'h77; branch_taken = 1'b1; #1;
        check("t5_flush", flush_id, 32'h1);
        check("t5_no_stall", stall_id, 32'h0);
        step();
        branch_taken = 1'b0;
        set_id(1'b1, 5'd4, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 32'h0);
        rf_data_a = 32'h31; #1;
        check("t5_flush_released", flush_id, 32'h0);
        step();
        nop(); mem_alu_result = 32'h99; wb_data = 32'h98; #1;
        check("t5_bubble_no_fwd", exe_opa, 32'h31);
        drain();

        // Memory wait for 3 cycles while sub is being forwarded from MEM
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 32'h0);
        rf_data_a = 32'h1; rf_data_b = 32'h2; #1; step();
        set_id(1'b1, 5'd3, 5'd5, 1'b1, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0, 32'h0);
        rf_data_a = 32'h0; rf_data_b = 32'h5; #1; step();
        set_id(1'b1, 5'd6, 5'd0, 1'b1, 1'b0, 1'b1, 5'd6, 1'b0, 1'b0, 1'b0, 32'h0);
        rf_data_a = 32'h44; mem_alu_result = 32'h10;
        mem_busy = 1'b1; branch_taken = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t6_hold", hold_all, 32'h1);
            check("t6_flush_gated", flush_id, 32'h0);
            check("t6_opa_frozen", exe_opa, 32'h10);
            step();
        end
        mem_busy = 1'b0; branch_taken = 1'b0; #1;
        check("t6_hold_released", hold_all, 32'h0);
        check("t6_opa_resume", exe_opa, 32'h10);
        step();
        nop(); #1;
        check("t6_next_opa", exe_opa, 32'h44);
        drain();

        // lw $2 ; sw $2,4($0)
        set_id(1'b1, 5'd0, 5'd2, 1'b1, 1'b0, 1'b1, 5'd2, 1'b1, 1'b0, 1'b1, 32'h0);
        #1; step();
        set_id(1'b1, 5'd0, 5'd2, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 32'h4);
        rf_data_b = 32'h13; mem_store_raw = 32'h13; #1;
`ifdef FWD_STORE_EN
        check("t7_store_nostall", stall_id, 32'h0);
        step();
        nop(); mem_store_raw = 32'h13; #1;
        check("t7_opb_imm", exe_opb, 32'h4);
        check("t7_store_raw_before", mem_store_data, 32'h13);
        step();
        wb_data = 32'h66; #1;
        check("t7_store_fwd", mem_store_data, 32'h66);
`else
        check("t7_store_stall", stall_id, 32'h1);
        step();
        check("t7_store_stall_once", stall_id, 32'h0);
        step();
        nop(); wb_data = 32'h66; mem_store_raw = 32'h13; #1;
        check("t7_opb_imm", exe_opb, 32'h4);
        check("t7_rt_data_wb", exe_rt_data, 32'h66);
        check("t7_store_raw", mem_store_data, 32'h13);
`endif
        drain();

        // Two producers of $3 in flight -> youngest (E) wins
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 32'h0);
        #1; step();
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 32'h0);
        #1; step();
        set_id(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0, 32'h0);
        rf_data_a = 32'h0; #1;
        check("t8_nostall", stall_id, 32'h0);
        step();
        nop(); mem_alu_result = 32'h22; wb_data = 32'h11; #1;
        check("t8_youngest_wins", exe_opa, 32'h22);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
